// File: rtl/vga_scan_timing.sv
// Raster scan generator for the analogue clock display: pixel counters, frame-aligned
// redraw square wave, and sync/display-enable delayed to line up with the renderer's pixel.
module vga_scan_timing #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_POL        = 0,
  parameter int CLK_DIV         = 1,
  parameter int PIX_LATENCY     = 1,
  parameter int FRAMES_PER_TICK = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pixel_in,
  output logic [9:0] horizCounter,
  output logic [9:0] vertCounter,
  output logic       slow_clk,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       vga_px
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W   = $clog2(FRAMES_PER_TICK);

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_TICK - 1);
  localparam logic [FRM_W-1:0] FRM_HALF = FRM_W'(FRAMES_PER_TICK / 2);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [9:0]       h_reg;
  logic [9:0]       v_reg;
  logic [FRM_W-1:0] frame_cnt_reg;
  logic             frame_start_reg;
  logic             slow_clk_reg;
  logic [2:0]       dly_reg [PIX_LATENCY];

  logic       pix_en;
  logic       h_last;
  logic       v_last;
  logic       frame_wrap;
  logic [2:0] raw_decode;
  logic [2:0] dly_out;

  assign pix_en     = enable && (div_cnt_reg == DIV_LAST);
  assign h_last     = (h_reg == H_LAST);
  assign v_last     = (v_reg == V_LAST);
  assign frame_wrap = pix_en && h_last && v_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (enable) begin
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_reg <= '0;
        v_reg <= v_last ? '0 : v_reg + 1'b1;
      end else begin
        h_reg <= h_reg + 1'b1;
      end
    end
  end

  // slow_clk samples the pre-increment frame count so the first frame after reset drives it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg   <= '0;
      frame_start_reg <= 1'b0;
      slow_clk_reg    <= 1'b0;
    end else begin
      frame_start_reg <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_reg <= (frame_cnt_reg == FRM_LAST) ? '0 : frame_cnt_reg + 1'b1;
        slow_clk_reg  <= (frame_cnt_reg < FRM_HALF);
      end
    end
  end

  assign raw_decode = {(h_reg >= HS_START) && (h_reg < HS_END),
                       (v_reg >= VS_START) && (v_reg < VS_END),
                       (h_reg < H_VIS) && (v_reg < V_VIS)};

  // Shifts every clk so the decode stays aligned with the renderer even while the scan is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIX_LATENCY; i++) dly_reg[i] <= '0;
    end else begin
      dly_reg[0] <= raw_decode;
      for (int i = 1; i < PIX_LATENCY; i++) dly_reg[i] <= dly_reg[i-1];
    end
  end

  assign dly_out      = dly_reg[PIX_LATENCY-1];
  assign horizCounter = h_reg;
  assign vertCounter  = v_reg;
  assign frame_start  = frame_start_reg;
  assign slow_clk     = slow_clk_reg;
  assign hsync        = (SYNC_POL != 0) ? dly_out[2] : ~dly_out[2];
  assign vsync        = (SYNC_POL != 0) ? dly_out[1] : ~dly_out[1];
  assign de           = dly_out[0];
  assign vga_px       = pixel_in & dly_out[0];

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

- Generates the raster scan that drives the analogue clock display.
- Produces the horizontal/vertical pixel counters that the clock renderer uses to read its framebuffer.
- Drives the renderer's `slow_clk` redraw request, aligned to frame boundaries.
- Takes back the renderer's registered pixel and emits a latency-aligned VGA pixel with matching hsync/vsync/display-enable.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync asserted level (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel (≥1)
- PIX_LATENCY, 1, clk cycles from counter change to `pixel_in` valid (≥1)
- FRAMES_PER_TICK, 60, `slow_clk` period in frames (even, ≥2)

Ports:
- clk, in, 1, system clock; reset, asynchronous, active-high
- reset, in, 1, asynchronous active-high reset
- enable, in, 1, run scan; low freezes the scan
- pixel_in, in, 1, renderer pixel, valid PIX_LATENCY cycles after the counters
- horizCounter, out, 10, current pixel column (0..H_TOTAL-1)
- vertCounter, out, 10, current line (0..V_TOTAL-1)
- slow_clk, out, 1, frame-aligned square wave, period FRAMES_PER_TICK frames
- frame_start, out, 1, one-clk pulse when the counters enter (0,0)
- hsync, out, 1, delayed horizontal sync
- vsync, out, 1, delayed vertical sync
- de, out, 1, delayed display enable
- vga_px, out, 1, pixel_in AND de (combinational)

## Operation

- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Pixel enable `pix_en`:
  - div_cnt counts 0..CLK_DIV-1 on every clk while enable=1.
  - pix_en = enable && div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_en = enable.
- Counters, on pix_en:
  - h increments.
  - At h==H_TOTAL-1: h wraps to 0 and v increments.
  - At v==V_TOTAL-1 together with the h wrap: v wraps to 0.
- Undelayed decode:
  - hs_raw while H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw while V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - de_raw while h<H_ACTIVE && v<V_ACTIVE.
- Delay line:
  - hs_raw, vs_raw and de_raw each pass through PIX_LATENCY clk-domain flops (every clk, not pix_en).
  - Output polarity: hsync = SYNC_POL ? hs_d : !hs_d; vsync the same rule.
- frame_start is a registered pulse: high for exactly one clk after the pix_en edge that moves (h,v) from (H_TOTAL-1,V_TOTAL-1) to (0,0).
- slow_clk:
  - frame_cnt counts 0..FRAMES_PER_TICK-1 and increments with each frame_start.
  - slow_clk = (frame_cnt < FRAMES_PER_TICK/2), registered, so it changes only on the frame_start cycle.
  - Because of this, renderer redraws always begin at frame 0.
- enable=0:
  - div_cnt, h, v and frame_cnt hold their values.
  - Delay line keeps shifting the held decode.
  - On re-enable, the scan resumes from the held position.

## Timing

- Reset values:
  - h = v = 0, div_cnt = 0, frame_cnt = 0.
  - Delay flops = 0, so hsync = vsync = inactive level (1 for SYNC_POL=0).
  - de = 0, vga_px = 0, frame_start = 0, slow_clk = 0.
- slow_clk goes to 1 at the first frame_start after reset (frame_cnt 0 → 1 ≤ half); not before.
- Counter outputs are registered and change on the clk edge where pix_en=1.
- Latency from counter value to its hsync/vsync/de: exactly PIX_LATENCY clk.
- vga_px carries no added latency beyond pixel_in.
- Frame length: H_TOTAL·V_TOTAL·CLK_DIV clk (420000 at defaults).
- Reset mid-frame:
  - All state returns to reset values immediately (asynchronous).
  - Scan restarts at (0,0) on the first clk after release.
  - No frame_start pulse for the restart.
- Simultaneous h wrap and v wrap: handled in one edge; frame_start asserts the following clk.

## Test plan

1. Reset, then release with enable=1 and default parameters:
   - Before the first edge: h=0, v=0, hsync=1, vsync=1, de=0, slow_clk=0.
   - After 800 clk: h=0, v=1.
2. Sample at h=655/656/751/752 on line 0:
   - hsync falls exactly 1 clk after h becomes 656.
   - hsync rises 1 clk after h becomes 752.
   - de falls 1 clk after h becomes 640.
3. Run two full frames:
   - vsync low for exactly 2·800 clk, starting 1 clk after v becomes 490.
   - frame_start is a single-clk pulse every 420000 clk.
4. Small parameters (H 8/1/1/1, V 4/1/1/1, FRAMES_PER_TICK=4):
   - slow_clk goes high at frame 1, toggles every 2 frames after that, and changes only on frame_start cycles.
5. CLK_DIV=3 and PIX_LATENCY=2:
   - Counters step every 3 clk.
   - de lags de_raw by 2 clk.
   - vga_px = pixel_in only while de=1; pixel_in=1 with de=0 gives vga_px=0.
6. Mid-frame events:
   - enable=0 at h=100, v=50 for 20 clk: counters hold at (100,50); scan resumes at 101 after re-enable.
   - Reset asserted mid-frame at h=300, v=200: all outputs go to reset values within the same cycle.
